// File: rtl/coord_pkg.sv
// Purpose: shared constants and types for the coordinate frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coord_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'd83;  // 'S'
  localparam logic [7:0] END_BYTE      = 8'd69;  // 'E'
  localparam int         PAYLOAD_BYTES = 12;     // 6 x 16-bit, MSB first
  localparam int         COORD_W       = 96;

  // Index of the last payload byte, in the width of the payload counter.
  localparam logic [3:0] LAST_PAYLOAD = 4'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_TRAILER = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [1:0] ERR_BAD_END  = 2'd0;
  localparam logic [1:0] ERR_BYTE_TO  = 2'd1;
  localparam logic [1:0] ERR_PARSE_TO = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

endpackage

// File: rtl/sat_counter16.sv
// Purpose: 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; every inc pulse is counted until saturation.
// Ports: clock, clr (sync clear, wins over inc), inc (count enable), count (value).
module sat_counter16 (
  input  logic        clock,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clock) begin
    if (clr) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/coord_frame_ctrl.sv
// Purpose: frames UART bytes (sync, 12 payload, end), feeds the coordinate parser, polices timeouts.
// Latency: forwarded bytes and all status outputs are registered, 1 cycle after the sampled input.
// Backpressure: none on rx; bytes arriving while a frame awaits the parser are dropped as an overrun.
// Ports: clock/reset; rx_byte/rx_valid from UART; parser_ready/parser_coords from parser;
//        parser_byte/parser_we/parser_reset to parser; coords/coords_valid frame result;
//        frame_err/err_code error report; good_count/drop_count saturating statistics.
module coord_frame_ctrl
  import coord_pkg::*;
#(
  parameter int BYTE_TIMEOUT  = 50000,
  parameter int PARSE_TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  input  logic               parser_ready,
  input  logic [COORD_W-1:0] parser_coords,
  output logic [7:0]         parser_byte,
  output logic               parser_we,
  output logic               parser_reset,
  output logic [COORD_W-1:0] coords,
  output logic               coords_valid,
  output logic               frame_err,
  output logic [1:0]         err_code,
  output logic [15:0]        good_count,
  output logic [15:0]        drop_count
);

  // The shared timer holds the number of idle cycles already elapsed in the
  // current state; the timeout fires on the cycle where it would reach the limit,
  // so frame_err rises exactly LIMIT edges after the edge that started the timer.
  localparam logic [15:0] BYTE_TO_LAST  = 16'(BYTE_TIMEOUT - 1);
  localparam logic [15:0] PARSE_TO_LAST = 16'(PARSE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic        fwd;        // accept rx_byte and pass it to the parser
  logic        err;        // error entry this cycle
  logic [1:0]  err_kind;
  logic        good;       // parser finished a validated frame
  logic        drop_byte;  // byte discarded while recovering

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HUNT;
      cnt_q   <= 4'd0;
      timer_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    fwd       = 1'b0;
    err       = 1'b0;
    err_kind  = ERR_BAD_END;
    good      = 1'b0;
    drop_byte = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          fwd     = 1'b1;
          cnt_d   = 4'd0;
          timer_d = 16'd0;
          state_d = ST_PAYLOAD;
        end
      end

      // Sync-valued bytes here are payload data; no resync inside a frame.
      ST_PAYLOAD: begin
        if (rx_valid) begin
          fwd     = 1'b1;
          timer_d = 16'd0;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_PAYLOAD) begin
            state_d = ST_TRAILER;
          end
        end else if (timer_q == BYTE_TO_LAST) begin
          err      = 1'b1;
          err_kind = ERR_BYTE_TO;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_TRAILER: begin
        if (rx_valid) begin
          if (rx_byte == END_BYTE) begin
            fwd     = 1'b1;
            timer_d = 16'd0;
            state_d = ST_WAIT;
          end else begin
            err      = 1'b1;
            err_kind = ERR_BAD_END;
          end
        end else if (timer_q == BYTE_TO_LAST) begin
          err      = 1'b1;
          err_kind = ERR_BYTE_TO;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      // Ready has priority: a completed parse is never discarded. A byte that
      // coincides with ready is ignored as if it arrived in HUNT.
      ST_WAIT: begin
        if (parser_ready) begin
          good    = 1'b1;
          state_d = ST_HUNT;
        end else if (rx_valid) begin
          err      = 1'b1;
          err_kind = ERR_OVERRUN;
        end else if (timer_q == PARSE_TO_LAST) begin
          err      = 1'b1;
          err_kind = ERR_PARSE_TO;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_RECOVER: begin
        drop_byte = rx_valid;
        state_d   = ST_HUNT;
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (err) begin
      state_d = ST_RECOVER;
    end
  end

  // Registered outputs. parser_reset is issued from RECOVER, which is never a
  // forwarding state, so it cannot overlap parser_we.
  always_ff @(posedge clock) begin
    if (reset) begin
      parser_byte  <= 8'd0;
      parser_we    <= 1'b0;
      parser_reset <= 1'b0;
      coords       <= '0;
      coords_valid <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      parser_we    <= fwd;
      parser_reset <= (state_q == ST_RECOVER);
      coords_valid <= good;
      frame_err    <= err;
      if (fwd) begin
        parser_byte <= rx_byte;
      end
      if (good) begin
        coords <= parser_coords;
      end
      if (err) begin
        err_code <= err_kind;
      end
    end
  end

  sat_counter16 u_good_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (good),
    .count (good_count)
  );

  sat_counter16 u_drop_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (err | drop_byte),
    .count (drop_count)
  );

endmodule

// File: tb/tb_coord_frame_ctrl.sv
// Purpose: randomized scoreboard bench for coord_frame_ctrl.
// Latency: expectations carry the exact cycle each output event must appear.
// Backpressure: n/a.
module tb_coord_frame_ctrl;
  import coord_pkg::*;

  localparam int BYTE_TO  = 400;
  localparam int PARSE_TO = 64;

  localparam int K_GOOD     = 0;
  localparam int K_BAD_END  = 1;
  localparam int K_BYTE_TO  = 2;
  localparam int K_PARSE_TO = 3;
  localparam int K_OVERRUN  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        parser_ready;
  logic [95:0] parser_coords;
  logic [7:0]  parser_byte;
  logic        parser_we;
  logic        parser_reset;
  logic [95:0] coords;
  logic        coords_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] good_count;
  logic [15:0] drop_count;

  coord_frame_ctrl #(.BYTE_TIMEOUT(BYTE_TO), .PARSE_TIMEOUT(PARSE_TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .parser_ready  (parser_ready),
    .parser_coords (parser_coords),
    .parser_byte   (parser_byte),
    .parser_we     (parser_we),
    .parser_reset  (parser_reset),
    .coords        (coords),
    .coords_valid  (coords_valid),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .good_count    (good_count),
    .drop_count    (drop_count)
  );

  typedef struct { logic [7:0] b; int c; } fwd_t;
  typedef struct { logic [95:0] crd; int good; int c; } good_t;
  typedef struct { logic [1:0] code; int drop; int c; logic [95:0] crd; } err_t;

  fwd_t  fwd_q[$];
  good_t good_q[$];
  err_t  err_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_pulses = 0;
  int last_err_cyc = -10;
  int m_good = 0;
  int m_drop = 0;
  logic [95:0] m_coords = '0;
  logic [7:0]  pay [12];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, pops one expectation per event.
  always @(negedge clock) begin
    fwd_t f;
    good_t g;
    err_t e;
    if (parser_we === 1'b1) begin
      we_pulses++;
      if (fwd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL parser_we_unexpected actual=byte %0h required=no write (cycle %0d)", parser_byte, cyc);
      end else begin
        f = fwd_q.pop_front();
        chk("parser_byte", parser_byte, f.b);
        chk("parser_we_cycle", cyc, f.c);
      end
    end
    if (parser_reset === 1'b1) begin
      chk("parser_reset_with_we", parser_we, 1'b0);
      chk("parser_reset_cycle", cyc, last_err_cyc + 1);
    end
    if (coords_valid === 1'b1) begin
      if (good_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL coords_valid_unexpected actual=%0h required=no pulse (cycle %0d)", coords, cyc);
      end else begin
        g = good_q.pop_front();
        chk("coords", coords, g.crd);
        chk("good_count", good_count, g.good);
        chk("coords_valid_cycle", cyc, g.c);
      end
    end
    if (frame_err === 1'b1) begin
      last_err_cyc = cyc;
      if (err_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL frame_err_unexpected actual=code %0d required=no error (cycle %0d)", err_code, cyc);
      end else begin
        e = err_q.pop_front();
        chk("err_code", err_code, e.code);
        chk("drop_count", drop_count, e.drop);
        chk("frame_err_cycle", cyc, e.c);
        chk("coords_held_on_err", coords, e.crd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Presents one byte; it is sampled at the edge numbered cyc+1.
  task automatic put(input logic [7:0] b, input bit fwd);
    rx_byte  = b;
    rx_valid = 1'b1;
    if (fwd) fwd_q.push_back('{b: b, c: cyc + 1});
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic exp_err(input logic [1:0] code, input int c);
    if (m_drop < 65535) m_drop++;
    err_q.push_back('{code: code, drop: m_drop, c: c, crd: m_coords});
  endtask

  function automatic logic [95:0] packed_payload();
    logic [95:0] p = '0;
    for (int i = 0; i < 12; i++) p = {p[87:0], pay[i]};
    return p;
  endfunction

  task automatic junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC_BYTE) b = 8'h50;
      put(b, 1'b0);
      tick(1);
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 12; i++) pay[i] = 8'($urandom);
  endtask

  // arg: ready delay (good), byte count before silence (byte timeout),
  // wait cycle of the stray byte (overrun). spacing 0 means random 1..12.
  task automatic frame(input int kind, input int arg, input int spacing, input bit drop_after);
    int n;
    int gap;
    int last;
    int w;
    int e_cyc;
    logic [7:0] b;
    put(SYNC_BYTE, 1'b1);
    last = cyc;
    n = (kind == K_BYTE_TO) ? arg : 12;
    for (int i = 0; i < n; i++) begin
      gap = (spacing > 0) ? spacing : int'($urandom_range(1, 12));
      tick(gap - 1);
      put(pay[i], 1'b1);
      last = cyc;
    end
    if (kind == K_BYTE_TO) begin
      e_cyc = last + BYTE_TO;
      exp_err(ERR_BYTE_TO, e_cyc);
      tick(e_cyc - cyc);
    end else begin
      gap = (spacing > 0) ? spacing : int'($urandom_range(1, 12));
      tick(gap - 1);
      if (kind == K_BAD_END) begin
        b = 8'($urandom);
        if (b == END_BYTE) b = 8'h00;
        exp_err(ERR_BAD_END, cyc + 1);
        put(b, 1'b0);
      end else begin
        put(END_BYTE, 1'b1);
        w = cyc;
        parser_coords = {$urandom, $urandom, $urandom};
        if (kind == K_GOOD) begin
          tick(arg - 1);
          parser_coords = packed_payload();
          parser_ready  = 1'b1;
          if (m_good < 65535) m_good++;
          m_coords = parser_coords;
          good_q.push_back('{crd: parser_coords, good: m_good, c: cyc + 1});
          tick(1);
          parser_ready = 1'b0;
        end else if (kind == K_PARSE_TO) begin
          exp_err(ERR_PARSE_TO, w + PARSE_TO);
          tick(PARSE_TO);
        end else begin
          tick(arg - 1);
          exp_err(ERR_OVERRUN, cyc + 1);
          put(8'($urandom), 1'b0);
        end
      end
    end
    if (kind != K_GOOD) begin
      // cyc is now the error edge; the next sampled byte lands in RECOVER.
      if (drop_after) begin
        if (m_drop < 65535) m_drop++;
        put(8'($urandom), 1'b0);
      end
      tick(1);
    end
  endtask

  initial begin
    int w0;
    int kind;
    int arg;
    reset = 1'b1;
    rx_byte = 8'd0;
    rx_valid = 1'b0;
    parser_ready = 1'b0;
    parser_coords = '0;
    tick(3);
    reset = 1'b0;
    chk("reset_coords", coords, 96'd0);
    chk("reset_good_count", good_count, 16'd0);
    chk("reset_drop_count", drop_count, 16'd0);
    chk("reset_err_code", err_code, 2'd0);
    chk("reset_pulses", {parser_we, parser_reset, coords_valid, frame_err}, 4'd0);
    tick(2);

    // Known frame, 10-cycle spacing, ready 5 cycles after the end byte.
    for (int i = 0; i < 12; i++) pay[i] = 8'(i + 1);
    w0 = we_pulses;
    frame(K_GOOD, 5, 10, 1'b0);
    tick(2);
    chk("t1_we_pulses", we_pulses - w0, 14);
    chk("t1_coords", coords, 96'h0102_0304_0506_0708_090A_0B0C);

    // Wrong end byte.
    rand_payload();
    frame(K_BAD_END, 0, 10, 1'b0);
    chk("t2_coords_unchanged", coords, 96'h0102_0304_0506_0708_090A_0B0C);
    tick(2);

    // Silence after three payload bytes.
    frame(K_BYTE_TO, 3, 10, 1'b0);
    tick(2);

    // Parser never ready, then ready on the last allowed cycle.
    rand_payload();
    frame(K_PARSE_TO, 0, 3, 1'b0);
    tick(1);
    rand_payload();
    frame(K_GOOD, PARSE_TO, 3, 1'b0);
    tick(1);

    // Leading non-sync byte ignored; sync value as first payload byte is data.
    put(8'd50, 1'b0);
    tick(1);
    rand_payload();
    pay[0] = 8'h53;
    frame(K_GOOD, 3, 2, 1'b0);
    tick(1);

    // Randomized frame mix, including drops during recovery.
    for (int t = 0; t < 40; t++) begin
      junk($urandom_range(0, 2));
      rand_payload();
      kind = $urandom_range(0, 4);
      case (kind)
        K_GOOD:    arg = $urandom_range(1, PARSE_TO);
        K_BYTE_TO: arg = $urandom_range(0, 12);
        K_OVERRUN: arg = $urandom_range(1, PARSE_TO - 1);
        default:   arg = 0;
      endcase
      frame(kind, arg, 0, 1'($urandom_range(0, 1)));
      tick($urandom_range(0, 3));
    end
    tick(2);
    chk("rand_good_count", good_count, 16'(m_good));
    chk("rand_drop_count", drop_count, 16'(m_drop));

    // Reset mid-payload abandons the frame silently.
    rand_payload();
    put(SYNC_BYTE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      put(pay[i], 1'b1);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    m_good = 0;
    m_drop = 0;
    m_coords = '0;
    chk("t6_coords", coords, 96'd0);
    chk("t6_counts", {good_count, drop_count}, 32'd0);
    chk("t6_err_code", err_code, 2'd0);
    chk("t6_pulses", {parser_we, parser_reset, coords_valid, frame_err}, 4'd0);
    chk("t6_parser_byte", parser_byte, 8'd0);
    tick(1);
    rand_payload();
    frame(K_GOOD, 4, 0, 1'b0);
    tick(2);
    chk("t6_good_count", good_count, 16'd1);

    tick(4);
    chk("fwd_q_drained", fwd_q.size(), 0);
    chk("good_q_drained", good_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
